bit_reorder_ctrl: RTL and testbench

Runtime-programmable bit permutation stage with a controller in front of it. A shadow permutation map is loaded one entry per cycle over a config port. On commit, a sequencer checks that the map is a true permutation, drains the registered datapath, then swaps the map in atomically. Used wherever the fixed-parameter reorder must instead be reconfigured by software or MyHDL without resynthesis.

---
 rtl/bit_reorder_ctrl_if.sv | 35 +++
 rtl/bit_reorder_ctrl.sv | 145 ++++++++++++++
 tb/tb_bit_reorder_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/bit_reorder_ctrl_if.sv
// Config and datapath bundle for bit_reorder_ctrl.
// The master drives config writes and input words; the slave is the reorder stage.
interface bit_reorder_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 5
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [IDX_WIDTH-1:0]  cfg_idx;
    logic [IDX_WIDTH-1:0]  cfg_src;
    logic                  cfg_commit;
    logic                  cfg_done;
    logic                  cfg_ok;
    logic                  map_error;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out;

    modport master (
        output cfg_valid, cfg_idx, cfg_src, cfg_commit,
        output in_valid, in, out_ready,
        input  cfg_ready, cfg_done, cfg_ok, map_error,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  cfg_valid, cfg_idx, cfg_src, cfg_commit,
        input  in_valid, in, out_ready,
        output cfg_ready, cfg_done, cfg_ok, map_error,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/bit_reorder_ctrl.sv
// Runtime-programmable bit permutation with a check/drain/swap commit sequencer.
// out[i] = in[active_map[i]], one register of latency.
module bit_reorder_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    bit_reorder_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {RUN, CHECK, DRAIN, SWAP} state_t;

    localparam logic [IDX_WIDTH-1:0] K_ONE = 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDX_WIDTH-1:0]  r_active_map [DATA_WIDTH];
    logic [IDX_WIDTH-1:0]  r_shadow_map [DATA_WIDTH];
    logic [DATA_WIDTH-1:0] r_seen;
    logic                  r_bad;
    logic [IDX_WIDTH-1:0]  r_k;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out;
    logic                  r_cfg_done;
    logic                  r_cfg_ok;
    logic                  r_map_error;

    logic [DATA_WIDTH-1:0] w_perm;
    logic [IDX_WIDTH-1:0]  w_s;
    logic                  w_entry_bad;
    logic                  w_last;
    logic                  w_fail;
    logic                  w_cfg_ready;
    logic                  w_cfg_wr;
    logic                  w_commit;
    logic                  w_in_ready;
    logic                  w_accept;

    assign w_s         = r_shadow_map[r_k];
    assign w_entry_bad = (int'(w_s) >= DATA_WIDTH) || r_seen[w_s];
    assign w_last      = (int'(r_k) == DATA_WIDTH - 1);
    assign w_fail      = (r_state == CHECK) && w_last && (r_bad || w_entry_bad);
    assign w_cfg_ready = (r_state == RUN);
    assign w_cfg_wr    = bus.cfg_valid && w_cfg_ready &&
                         (int'(bus.cfg_idx) < DATA_WIDTH);
    assign w_commit    = (r_state == RUN) && bus.cfg_commit;
    assign w_in_ready  = (r_state != DRAIN) && (r_state != SWAP) &&
                         (!r_out_valid || bus.out_ready);
    assign w_accept    = bus.in_valid && w_in_ready;

    assign bus.cfg_ready = w_cfg_ready;
    assign bus.cfg_done  = r_cfg_done;
    assign bus.cfg_ok    = r_cfg_ok;
    assign bus.map_error = r_map_error;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;

    // Apply the active map to the incoming word.
    always_comb begin
        w_perm = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_perm[i] = bus.in[r_active_map[i]];
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RUN;
        else        r_state <= w_state_nxt;
    end

    // Commit sequencer: validate shadow, wait for empty output, swap.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RUN:   if (w_commit) w_state_nxt = CHECK;
            CHECK: if (w_last) w_state_nxt = w_fail ? RUN : DRAIN;
            DRAIN: if (!r_out_valid || bus.out_ready) w_state_nxt = SWAP;
            SWAP:  w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    // Walk the shadow map, tracking which sources were already used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seen <= '0;
            r_bad  <= 1'b0;
            r_k    <= '0;
        end else if (w_commit) begin
            r_seen <= '0;
            r_bad  <= 1'b0;
            r_k    <= '0;
        end else if (r_state == CHECK) begin
            if (w_entry_bad) r_bad <= 1'b1;
            else             r_seen[w_s] <= 1'b1;
            r_k <= r_k + K_ONE;
        end
    end

    // Shadow map written by software, active map swapped in whole.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                r_shadow_map[i] <= IDX_WIDTH'(i);
                r_active_map[i] <= IDX_WIDTH'(i);
            end
        end else begin
            if (w_cfg_wr) r_shadow_map[bus.cfg_idx] <= bus.cfg_src;
            if (r_state == SWAP) r_active_map <= r_shadow_map;
        end
    end

    // Commit status: done pulse, result flag, sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_done  <= 1'b0;
            r_cfg_ok    <= 1'b0;
            r_map_error <= 1'b0;
        end else begin
            r_cfg_done <= w_fail || (r_state == SWAP);
            if (w_fail) begin
                r_cfg_ok    <= 1'b0;
                r_map_error <= 1'b1;
            end else if (r_state == SWAP) begin
                r_cfg_ok    <= 1'b1;
                r_map_error <= 1'b0;
            end
        end
    end

    // Single output register with valid/ready hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out       <= w_perm;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bit_reorder_ctrl.sv
// Directed bench for bit_reorder_ctrl.
// Covers identity pass, reject, accept, drain stall, streaming and async reset.
module tb_bit_reorder_ctrl;
    localparam int DW = 32;
    localparam int IW = 5;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   n;
    logic seen_done;

    bit_reorder_ctrl_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) u_if ();

    bit_reorder_ctrl #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int idx, input int src);
        u_if.cfg_valid = 1'b1;
        u_if.cfg_idx   = IW'(idx);
        u_if.cfg_src   = IW'(src);
        tick();
        u_if.cfg_valid = 1'b0;
    endtask

    task automatic commit();
        u_if.cfg_commit = 1'b1;
        tick();
        u_if.cfg_commit = 1'b0;
    endtask

    task automatic wait_done(input int start, output int cyc);
        cyc = start;
        while (!u_if.cfg_done && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic xfer(input logic [31:0] din, input logic [31:0] dexp,
                        input string tag);
        u_if.in        = din;
        u_if.in_valid  = 1'b1;
        u_if.out_ready = 1'b1;
        chk({tag, "_ird"}, 32'(u_if.in_ready), 32'd1);
        tick();
        u_if.in_valid = 1'b0;
        chk({tag, "_ov"}, 32'(u_if.out_valid), 32'd1);
        chk({tag, "_out"}, u_if.out, dexp);
    endtask

    task automatic load_map();
        cfg_write(1, 5);
        cfg_write(2, 6);
        cfg_write(3, 7);
        cfg_write(4, 1);
        cfg_write(5, 2);
        cfg_write(6, 3);
        cfg_write(7, 4);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        u_if.cfg_valid  = 1'b0;
        u_if.cfg_idx    = '0;
        u_if.cfg_src    = '0;
        u_if.cfg_commit = 1'b0;
        u_if.in_valid   = 1'b0;
        u_if.in         = '0;
        u_if.out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;

        chk("rst_ov", 32'(u_if.out_valid), 32'd0);
        chk("rst_out", u_if.out, 32'h0);
        chk("rst_done", 32'(u_if.cfg_done), 32'd0);
        chk("rst_ok", 32'(u_if.cfg_ok), 32'd0);
        chk("rst_err", 32'(u_if.map_error), 32'd0);
        chk("rst_crdy", 32'(u_if.cfg_ready), 32'd1);
        tick();

        xfer(32'hF0F0F0F0, 32'hF0F0F0F0, "id");
        tick();
        chk("id_drop", 32'(u_if.out_valid), 32'd0);

        cfg_write(3, 5);
        commit();
        wait_done(1, n);
        chk("rej_lat", n, 33);
        chk("rej_ok", 32'(u_if.cfg_ok), 32'd0);
        chk("rej_err", 32'(u_if.map_error), 32'd1);
        tick();
        chk("rej_pulse", 32'(u_if.cfg_done), 32'd0);
        xfer(32'hF0F0F0F0, 32'hF0F0F0F0, "rej_keep");

        load_map();
        commit();
        wait_done(1, n);
        chk("acc_lat", n, 35);
        chk("acc_ok", 32'(u_if.cfg_ok), 32'd1);
        chk("acc_err", 32'(u_if.map_error), 32'd0);
        xfer(32'hF0F0F0F0, 32'hF0F0F08E, "map_a");
        xfer(32'h00000020, 32'h00000002, "map_b");
        xfer(32'h00000002, 32'h00000010, "map_c");

        u_if.in         = 32'h12345678;
        u_if.in_valid   = 1'b1;
        u_if.out_ready  = 1'b0;
        u_if.cfg_commit = 1'b1;
        tick();
        u_if.in_valid   = 1'b0;
        u_if.cfg_commit = 1'b0;
        repeat (10) tick();
        chk("mid_ov", 32'(u_if.out_valid), 32'd1);
        chk("mid_crdy", 32'(u_if.cfg_ready), 32'd0);
        rst_n = 1'b0;
        #2;
        chk("arst_ov", 32'(u_if.out_valid), 32'd0);
        chk("arst_crdy", 32'(u_if.cfg_ready), 32'd1);
        #1 rst_n = 1'b1;
        u_if.out_ready = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            tick();
            if (u_if.cfg_done) seen_done = 1'b1;
        end
        chk("arst_nodone", 32'(seen_done), 32'd0);
        chk("arst_err", 32'(u_if.map_error), 32'd0);
        xfer(32'hF0F0F0F0, 32'hF0F0F0F0, "arst_id");

        u_if.in         = 32'hA5000000;
        u_if.in_valid   = 1'b1;
        u_if.out_ready  = 1'b1;
        u_if.cfg_commit = 1'b1;
        chk("st_ird0", 32'(u_if.in_ready), 32'd1);
        tick();
        u_if.cfg_commit = 1'b0;
        for (int k = 0; k < 32; k++) begin
            chk("st_out", u_if.out, u_if.in);
            chk("st_crdy", 32'(u_if.cfg_ready), 32'd0);
            chk("st_ird", 32'(u_if.in_ready), 32'd1);
            u_if.in        = 32'hA5000100 | 32'(k);
            u_if.cfg_valid = 1'b1;
            u_if.cfg_idx   = 5'd0;
            u_if.cfg_src   = 5'd3;
            tick();
        end
        u_if.cfg_valid = 1'b0;
        chk("st_last", u_if.out, 32'hA500011F);
        chk("st_drain_ird", 32'(u_if.in_ready), 32'd0);
        u_if.in_valid = 1'b0;
        wait_done(33, n);
        chk("st_lat", n, 35);
        chk("st_ok", 32'(u_if.cfg_ok), 32'd1);
        xfer(32'h0000000F, 32'h0000000F, "st_map");

        load_map();
        commit();
        wait_done(1, n);
        chk("d_lat0", n, 35);
        u_if.in        = 32'hF0F0F0F0;
        u_if.in_valid  = 1'b1;
        u_if.out_ready = 1'b0;
        tick();
        u_if.in_valid = 1'b0;
        chk("d_pend", 32'(u_if.out_valid), 32'd1);
        for (int i = 1; i < 8; i++) cfg_write(i, i);
        commit();
        repeat (32) tick();
        u_if.in       = 32'hFFFF0000;
        u_if.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("d_ird", 32'(u_if.in_ready), 32'd0);
            chk("d_ov", 32'(u_if.out_valid), 32'd1);
            chk("d_hold", u_if.out, 32'hF0F0F08E);
            chk("d_nodone", 32'(u_if.cfg_done), 32'd0);
            tick();
        end
        u_if.in_valid  = 1'b0;
        u_if.out_ready = 1'b1;
        chk("d_emit", u_if.out, 32'hF0F0F08E);
        tick();
        chk("d_swap_ov", 32'(u_if.out_valid), 32'd0);
        chk("d_swap_ird", 32'(u_if.in_ready), 32'd0);
        tick();
        chk("d_done", 32'(u_if.cfg_done), 32'd1);
        chk("d_ok", 32'(u_if.cfg_ok), 32'd1);
        xfer(32'hF0F0F0F0, 32'hF0F0F0F0, "d_new");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
